// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter sharing one mesh router output port between N_REQ input FIFOs.
// Pops one FIFO head per accepted word, holds it until out_rdy, and flags long stalls.
module mesh_port_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned bits      = 32,
  parameter int unsigned STALL_MAX = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           pndng,
  input  logic [N_REQ*bits-1:0]      din,
  output logic [N_REQ-1:0]           pop,
  output logic [bits-1:0]            dout,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       stall_err
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned SUM_W = ID_W + 1;
  localparam int unsigned CNT_W = $clog2(STALL_MAX + 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                 state, state_nxt;
  logic                   load;
  logic                   any_req;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        win;
  logic [ID_W-1:0]        off;
  logic [SUM_W-1:0]       sum;
  logic [2*N_REQ-1:0]     dbl;
  logic [N_REQ-1:0]       rot;
  logic [CNT_W-1:0]       stall_cnt;
  logic [bits-1:0]        words [N_REQ];

  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_slice
    assign words[g] = din[g*bits +: bits];
  end

  // Rotate requests so rr_ptr sits at bit 0, take the first set bit, rotate back.
  always_comb begin
    dbl = {pndng, pndng} >> rr_ptr;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (rot[k]) off = ID_W'(k);
    end
    sum = SUM_W'(rr_ptr) + SUM_W'(off);
    if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
    win     = sum[ID_W-1:0];
    any_req = |pndng;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Output register is free when empty or being drained this cycle; reset blocks any pop.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = '0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          load      = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_rdy) begin
          if (any_req) load = 1'b1;
          else         state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (rst) begin
      load      = 1'b0;
      state_nxt = S_IDLE;
    end
    if (load) pop = N_REQ'(1) << win;
  end

  assign out_vld = (state == S_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (load) begin
      dout     <= words[win];
      grant_id <= win;
      rr_ptr   <= (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
    end
  end

  // Watchdog: count blocked cycles, saturate, latch the error until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      if (!out_vld || out_rdy)                  stall_cnt <= '0;
      else if (stall_cnt != CNT_W'(STALL_MAX))  stall_cnt <= stall_cnt + CNT_W'(1);
      if (stall_cnt == CNT_W'(STALL_MAX))       stall_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Directed bench for mesh_port_arbiter: reset, grant order, backpressure, skip/wrap, watchdog.
module tb_mesh_port_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned BITS  = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      pndng;
  logic [N_REQ*BITS-1:0] din;
  logic [N_REQ-1:0]      pop;
  logic [BITS-1:0]       dout;
  logic                  out_vld;
  logic                  out_rdy;
  logic [1:0]            grant_id;
  logic                  stall_err;

  int tests_run    = 0;
  int tests_failed = 0;

  mesh_port_arbiter #(.N_REQ(N_REQ), .bits(BITS), .STALL_MAX(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .pndng     (pndng),
    .din       (din),
    .pop       (pop),
    .dout      (dout),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .grant_id  (grant_id),
    .stall_err (stall_err)
  );

  always #5 clk = ~clk;

  function automatic logic [BITS-1:0] word_of(input int i);
    return 32'hA5A5_0000 + BITS'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pndng = 4'b1111; out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) din[i*BITS +: BITS] = word_of(i);
    for (int c = 0; c < 2; c++) begin
      tick();
      tests_run++;
      if (pop !== 4'b0000 || out_vld !== 1'b0 || dout !== 32'h0 || grant_id !== 2'd0 || stall_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_state cyc%0d: pop=%b vld=%b dout=%h gid=%0d err=%b, want 0000 0 0 0 0",
                 c, pop, out_vld, dout, grant_id, stall_err);
      end
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (pop !== 4'b0001) begin
      tests_failed++;
      $display("FAIL reset_release_pop: got %b want 0001", pop);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_pop;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_pop = 4'b0001 << ((k + 1) % 4);
      tests_run++;
      if (out_vld !== 1'b1 || grant_id !== 2'(k % 4) || dout !== word_of(k % 4) || pop !== exp_pop) begin
        tests_failed++;
        $display("FAIL rr_grant k=%0d: vld=%b gid=%0d dout=%h pop=%b want 1 %0d %h %b",
                 k, out_vld, grant_id, dout, pop, k % 4, word_of(k % 4), exp_pop);
      end
    end
    pndng = 4'b0000;
    tick();
    tests_run++;
    if (out_vld !== 1'b0 || pop !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rr_drain: vld=%b pop=%b want 0 0000", out_vld, pop);
    end
  endtask

  task automatic test_single();
    pndng = 4'b0100;
    #1;
    tests_run++;
    if (pop !== 4'b0100) begin
      tests_failed++;
      $display("FAIL single_pop: got %b want 0100", pop);
    end
    tick();
    pndng = 4'b0000;
    #1;
    tests_run++;
    if (out_vld !== 1'b1 || dout !== 32'hA5A5_0002 || grant_id !== 2'd2 || pop !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_hold: vld=%b dout=%h gid=%0d pop=%b want 1 a5a50002 2 0000",
               out_vld, dout, grant_id, pop);
    end
    tick();
    tests_run++;
    if (out_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle: vld=%b want 0", out_vld);
    end
  endtask

  // rr_ptr is 3 here; requester 1 is reached only by wrapping past 3 and 0.
  task automatic test_skip_wrap();
    pndng = 4'b0010;
    #1;
    tests_run++;
    if (pop !== 4'b0010) begin
      tests_failed++;
      $display("FAIL wrap_pop: got %b want 0010", pop);
    end
    tick();
    pndng = 4'b0000;
    #1;
    tests_run++;
    if (out_vld !== 1'b1 || grant_id !== 2'd1 || dout !== word_of(1)) begin
      tests_failed++;
      $display("FAIL wrap_hold: vld=%b gid=%0d dout=%h want 1 1 %h", out_vld, grant_id, dout, word_of(1));
    end
    tick();
    tests_run++;
    if (out_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_idle: vld=%b want 0", out_vld);
    end
    pndng = 4'b0110;
    #1;
    tests_run++;
    if (pop !== 4'b0100) begin
      tests_failed++;
      $display("FAIL wrap_rrptr2: pop=%b want 0100", pop);
    end
    tick();
    pndng = 4'b0000;
    tick();
  endtask

  // Entered with rr_ptr=3, out register empty.
  task automatic test_backpressure();
    din[0 +: BITS] = 32'h0000_1234;
    pndng   = 4'b0011;
    out_rdy = 1'b0;
    #1;
    tests_run++;
    if (pop !== 4'b0001) begin
      tests_failed++;
      $display("FAIL bp_first_pop: got %b want 0001", pop);
    end
    tick();
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (out_vld !== 1'b1 || dout !== 32'h0000_1234 || grant_id !== 2'd0 || pop !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bp_hold c=%0d: vld=%b dout=%h gid=%0d pop=%b want 1 00001234 0 0000",
                 c, out_vld, dout, grant_id, pop);
      end
      if (c < 4) tick();
    end
    out_rdy = 1'b1;
    #1;
    tests_run++;
    if (pop !== 4'b0010) begin
      tests_failed++;
      $display("FAIL bp_release_pop: got %b want 0010", pop);
    end
    tick();
    tests_run++;
    if (out_vld !== 1'b1 || grant_id !== 2'd1 || dout !== word_of(1) || pop !== 4'b0001) begin
      tests_failed++;
      $display("FAIL bp_next: vld=%b gid=%0d dout=%h pop=%b want 1 1 %h 0001",
               out_vld, grant_id, dout, pop, word_of(1));
    end
    pndng = 4'b0000;
    tick();
    din[0 +: BITS] = word_of(0);
  endtask

  // Entered with rr_ptr=2, idle.
  task automatic test_watchdog();
    pndng   = 4'b0001;
    out_rdy = 1'b0;
    tick();
    pndng = 4'b0000;
    for (int c = 0; c < 100; c++) tick();
    tests_run++;
    if (stall_err !== 1'b0 || out_vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL wd_before: err=%b vld=%b want 0 1", stall_err, out_vld);
    end
    tick();
    tests_run++;
    if (stall_err !== 1'b1 || dout !== word_of(0) || grant_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL wd_set: err=%b dout=%h gid=%0d want 1 %h 0", stall_err, dout, grant_id, word_of(0));
    end
    out_rdy = 1'b1;
    tick();
    tick();
    tests_run++;
    if (stall_err !== 1'b1 || out_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_sticky: err=%b vld=%b want 1 0", stall_err, out_vld);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (stall_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_reset: err=%b want 0", stall_err);
    end
  endtask

  // Reset colliding with a transfer must not pop and must drop the held word.
  task automatic test_reset_mid_transfer();
    pndng   = 4'b1111;
    out_rdy = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (pop !== 4'b0000 || out_vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_xfer_pop: pop=%b vld=%b want 0000 1", pop, out_vld);
    end
    tick();
    tests_run++;
    if (out_vld !== 1'b0 || dout !== 32'h0 || grant_id !== 2'd0 || pop !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rst_xfer_state: vld=%b dout=%h gid=%0d pop=%b want 0 0 0 0000",
               out_vld, dout, grant_id, pop);
    end
    rst = 1'b0;
    pndng = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; pndng = '0; din = '0; out_rdy = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_skip_wrap();
    test_backpressure();
    test_watchdog();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
